// File: rtl/program_loader_pkg.sv
// Shared definitions for the in-system program loader: widths, frame type
// codes and the frame-decode state enum.
package program_loader_pkg;

    localparam int unsigned PL_ADDR_W  = 14;
    localparam int unsigned PL_INSTR_W = 30;
    localparam int unsigned PL_DATA_W  = 10;
    localparam int unsigned PL_BYTE_W  = 8;

    localparam logic [7:0] TYPE_INSTR = 8'h01;
    localparam logic [7:0] TYPE_DATA  = 8'h02;
    localparam logic [7:0] TYPE_RUN   = 8'h03;

    typedef enum logic [3:0] {
        HDR,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        PAYLOAD,
        CHECK,
        RUN,
        ERROR
    } state_e;

    // Terminal states stop consuming the stream.
    function automatic logic state_accepts(input state_e s);
        return !(s == RUN || s == ERROR);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects payload bytes (big-endian) into instruction or data words.
// `last` flags the byte that completes a word; `done`/`word` present the
// finished word for exactly one cycle afterwards.
module loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int unsigned INSTR_W = PL_INSTR_W,
    parameter int unsigned DATA_W  = PL_DATA_W,
    parameter int unsigned BYTE_W  = PL_BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_en,
    input  logic               is_instr,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic               last,
    output logic [INSTR_W-1:0] word,
    output logic               done
);

    localparam int unsigned InstrBytes = (INSTR_W + BYTE_W - 1) / BYTE_W;
    localparam int unsigned DataBytes  = (DATA_W + BYTE_W - 1) / BYTE_W;
    localparam int unsigned IdxW       = $clog2(InstrBytes);
    localparam int unsigned ShW        = (InstrBytes - 1) * BYTE_W;

    logic [IdxW-1:0]        idx_q;
    logic [IdxW-1:0]        idx_max;
    logic [ShW-1:0]         shift_q;
    logic [ShW+BYTE_W-1:0]  full;
    logic [INSTR_W-1:0]     word_q;
    logic                   done_q;

    // Detect the closing byte of the current word and form the complete word.
    always_comb begin
        idx_max = is_instr ? IdxW'(InstrBytes - 1) : IdxW'(DataBytes - 1);
        last    = byte_en && (idx_q == idx_max);
        full    = {shift_q, byte_in};
    end

    // Shift in bytes; latch the word and raise done the cycle after completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (byte_en) begin
                shift_q <= ShW'(full);
                idx_q   <= last ? '0 : idx_q + IdxW'(1);
            end
            if (last) begin
                // Truncating casts drop the unused top bits of the first byte.
                word_q <= is_instr ? INSTR_W'(full) : INSTR_W'(DATA_W'(full));
            end
        end
    end

    assign word = word_q;
    assign done = done_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: decodes INSTR/DATA/RUN frames, writes words into
// instruction/data memory and releases the core on RUN.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte to every frame (frame XOR including the checksum must be zero).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = PL_ADDR_W,
    parameter int unsigned INSTR_W = PL_INSTR_W,
    parameter int unsigned DATA_W  = PL_DATA_W,
    parameter int unsigned BYTE_W  = PL_BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_data,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_data,
    output logic               core_hold,
    output logic               core_clk_en,
    output logic               busy,
    output logic               error,
    output logic [ADDR_W:0]    words_written
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e FrameEnd = CHECK;
    localparam state_e RunEntry = CHECK;
`else
    localparam state_e FrameEnd = HDR;
    localparam state_e RunEntry = RUN;
`endif

    state_e             state_q, state_d;
    logic               live_q;
    logic               accept;
    logic               instr_q;
    logic [BYTE_W-1:0]  hi_q;
    logic [ADDR_W-1:0]  hilo;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  left_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic               wr_instr_q;
    logic [ADDR_W:0]    words_q;
    logic               asm_last;
    logic               asm_done;
    logic [INSTR_W-1:0] asm_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
    logic               run_q;
`endif

    // live_q keeps in_ready low while reset is asserted and for the first edge.
    assign in_ready = live_q && state_accepts(state_q);
    assign accept   = in_valid && in_ready;
    assign hilo     = ADDR_W'({hi_q, in_data});

    loader_word_assembler #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .BYTE_W  (BYTE_W)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .byte_en  (accept && (state_q == PAYLOAD)),
        .is_instr (instr_q),
        .byte_in  (in_data),
        .last     (asm_last),
        .word     (asm_word),
        .done     (asm_done)
    );

    // Frame-decode state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (accept) begin
                    if (in_data == TYPE_INSTR || in_data == TYPE_DATA) begin
                        state_d = ADDR_HI;
                    end else if (in_data == TYPE_RUN) begin
                        state_d = RunEntry;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ADDR_HI: if (accept) state_d = ADDR_LO;
            ADDR_LO: if (accept) state_d = CNT_HI;
            CNT_HI:  if (accept) state_d = CNT_LO;
            CNT_LO:  if (accept) state_d = (hilo == '0) ? FrameEnd : PAYLOAD;
            PAYLOAD: if (asm_last && (left_q == ADDR_W'(1))) state_d = FrameEnd;
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept) begin
                    if ((csum_q ^ in_data) == '0) begin
                        state_d = run_q ? RUN : HDR;
                    end else begin
                        state_d = ERROR;
                    end
                end
`else
                state_d = ERROR;
`endif
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // Frame fields, write address/count bookkeeping and the word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q     <= 1'b0;
            instr_q    <= 1'b0;
            hi_q       <= '0;
            addr_q     <= '0;
            left_q     <= '0;
            wr_addr_q  <= '0;
            wr_instr_q <= 1'b0;
            words_q    <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                if (state_q == HDR)                         instr_q <= (in_data == TYPE_INSTR);
                if (state_q == ADDR_HI || state_q == CNT_HI) hi_q    <= in_data;
                if (state_q == ADDR_LO)                     addr_q  <= hilo;
                if (state_q == CNT_LO)                      left_q  <= hilo;
            end
            // Capture the target of the word completing now; the strobe follows.
            if (asm_last) begin
                wr_addr_q  <= addr_q;
                wr_instr_q <= instr_q;
                addr_q     <= addr_q + ADDR_W'(1);
                left_q     <= left_q - ADDR_W'(1);
                words_q    <= words_q + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR of the frame, restarted by each header byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            run_q  <= 1'b0;
        end else if (accept) begin
            if (state_q == HDR) begin
                csum_q <= in_data;
                run_q  <= (in_data == TYPE_RUN);
            end else begin
                csum_q <= csum_q ^ in_data;
            end
        end
    end
`endif

    // Output decode: strobes, core control and status.
    always_comb begin
        imem_we       = asm_done && wr_instr_q;
        dmem_we       = asm_done && !wr_instr_q;
        imem_addr     = wr_addr_q;
        dmem_addr     = wr_addr_q;
        imem_data     = asm_word;
        dmem_data     = DATA_W'(asm_word);
        core_hold     = (state_q != RUN);
        core_clk_en   = (state_q == RUN);
        error         = (state_q == ERROR);
        // The trailing write cycle still belongs to the frame.
        busy          = (state_q inside {ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, PAYLOAD, CHECK})
                        || asm_done;
        words_written = words_q;
    end

endmodule
